// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// Module   : cpu_defs (package)
// Purpose  : Shared definitions for the ALU issue controller: opcode values,
//            ALU select encodings and the issue FSM state encoding.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package cpu_defs;

  // Opcodes, INSTR[31:24]
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  // ALU function select
  localparam logic [2:0] SEL_FWD  = 3'b000;
  localparam logic [2:0] SEL_ADD  = 3'b001;
  localparam logic [2:0] SEL_AND  = 3'b010;
  localparam logic [2:0] SEL_OR   = 3'b011;

  // Issue FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_EXEC   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_instr_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_instr_decode
// Purpose  : Combinational opcode decoder for the ALU issue controller.
// Ports    : i_op          opcode INSTR[31:24]
//            o_select      ALU function select
//            o_use_imm     operand 2 comes from IMM instead of REGOUT2
//            o_negate_op2  operand 2 is two's-complement negated (sub/beq)
//            o_zero_op1    operand 1 forced to zero (loadi/mov)
//            o_writes      opcode writes back a register
//            o_is_jump     unconditional branch
//            o_is_beq      branch on ALU zero
//            o_illegal     unknown opcode
// Revision : 1.0  initial release
// ============================================================================
module alu_instr_decode
  import cpu_defs::*;
(
  input  logic [7:0] i_op,
  output logic [2:0] o_select,
  output logic       o_use_imm,
  output logic       o_negate_op2,
  output logic       o_zero_op1,
  output logic       o_writes,
  output logic       o_is_jump,
  output logic       o_is_beq,
  output logic       o_illegal
);

  always_comb begin
    o_select     = SEL_FWD;
    o_use_imm    = 1'b0;
    o_negate_op2 = 1'b0;
    o_zero_op1   = 1'b0;
    o_writes     = 1'b0;
    o_is_jump    = 1'b0;
    o_is_beq     = 1'b0;
    o_illegal    = 1'b0;
    case (i_op)
      OP_LOADI: begin o_zero_op1 = 1'b1; o_use_imm = 1'b1; o_writes = 1'b1; end
      OP_MOV:   begin o_zero_op1 = 1'b1; o_writes = 1'b1; end
      OP_ADD:   begin o_select = SEL_ADD; o_writes = 1'b1; end
      OP_SUB:   begin o_select = SEL_ADD; o_negate_op2 = 1'b1; o_writes = 1'b1; end
      OP_AND:   begin o_select = SEL_AND; o_writes = 1'b1; end
      OP_OR:    begin o_select = SEL_OR;  o_writes = 1'b1; end
      OP_J:     o_is_jump = 1'b1;
      OP_BEQ:   begin o_select = SEL_ADD; o_negate_op2 = 1'b1; o_is_beq = 1'b1; end
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Issue-side controller for the 8-bit ALU. Accepts an instruction
//            over valid/ready, reads the register file, drives registered
//            ALU operands, samples RESULT/ZERO after ALU_WAIT cycles and
//            emits one writeback, branch or illegal strobe per instruction.
// Ports    : CLK, RESET_N            clock / async active-low reset
//            INSTR_VALID/INSTR/INSTR_READY   instruction handshake
//            BUSYWAIT                memory stall, freezes the FSM
//            READREG1/2, REGOUT1/2   register file read port
//            ALU_DATA1/2, ALU_SELECT ALU operands (registered)
//            ALU_RESULT, ALU_ZERO    ALU outputs
//            WRITE_EN/ADDR/DATA      register writeback
//            BRANCH_TAKEN/OFFSET     branch decision
//            ILLEGAL                 unknown-opcode strobe
// Revision : 1.0  initial release
// ============================================================================
module alu_issue_ctrl
  import cpu_defs::*;
#(
  parameter int ALU_WAIT = 1
)(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        INSTR_VALID,
  input  logic [31:0] INSTR,
  output logic        INSTR_READY,
  input  logic        BUSYWAIT,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  input  logic [7:0]  REGOUT1,
  input  logic [7:0]  REGOUT2,
  output logic [7:0]  ALU_DATA1,
  output logic [7:0]  ALU_DATA2,
  output logic [2:0]  ALU_SELECT,
  input  logic [7:0]  ALU_RESULT,
  input  logic        ALU_ZERO,
  output logic        WRITE_EN,
  output logic [2:0]  WRITE_ADDR,
  output logic [7:0]  WRITE_DATA,
  output logic        BRANCH_TAKEN,
  output logic [7:0]  BRANCH_OFFSET,
  output logic        ILLEGAL
);

  localparam logic [2:0] c_WAIT_LOAD = 3'(ALU_WAIT - 1);

  state_t      r_state, w_next;
  logic [31:0] r_instr;
  logic [2:0]  r_cnt;
  logic        r_zero;
  logic [7:0]  r_data1, r_data2, r_wdata;
  logic [2:0]  r_sel;

  logic [2:0]  w_select;
  logic        w_use_imm, w_negate_op2, w_zero_op1, w_writes;
  logic        w_is_jump, w_is_beq, w_illegal;
  logic        w_ready, w_accept, w_commit_go;
  logic [7:0]  w_op1, w_op2_src, w_op2;
  logic        w_unused;

  alu_instr_decode u_decode (
    .i_op         (r_instr[31:24]),
    .o_select     (w_select),
    .o_use_imm    (w_use_imm),
    .o_negate_op2 (w_negate_op2),
    .o_zero_op1   (w_zero_op1),
    .o_writes     (w_writes),
    .o_is_jump    (w_is_jump),
    .o_is_beq     (w_is_beq),
    .o_illegal    (w_illegal)
  );

  // Ready is forced low while reset is asserted so every output reads 0.
  assign w_ready     = RESET_N && !BUSYWAIT &&
                       ((r_state == ST_IDLE) || (r_state == ST_COMMIT));
  assign w_accept    = INSTR_VALID && w_ready;
  assign w_commit_go = (r_state == ST_COMMIT) && !BUSYWAIT;

  // Operand selection; negation wraps modulo 256 (0x80 maps to itself).
  assign w_op1     = w_zero_op1 ? 8'h00 : REGOUT1;
  assign w_op2_src = w_use_imm ? r_instr[7:0] : REGOUT2;
  assign w_op2     = w_negate_op2 ? (~w_op2_src + 8'd1) : w_op2_src;

  // Field bits RT[15:11] are not used by the 8-register file.
  assign w_unused = ^r_instr[15:11];

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next state and commit strobes
  always_comb begin
    w_next       = r_state;
    INSTR_READY  = w_ready;
    WRITE_EN     = 1'b0;
    BRANCH_TAKEN = 1'b0;
    ILLEGAL      = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_READ;
      ST_READ:   if (!BUSYWAIT) w_next = ST_EXEC;
      ST_EXEC:   if (!BUSYWAIT && (r_cnt == 3'd0)) w_next = ST_COMMIT;
      ST_COMMIT: begin
        if (w_commit_go) begin
          WRITE_EN     = w_writes;
          BRANCH_TAKEN = w_is_jump || (w_is_beq && r_zero);
          ILLEGAL      = w_illegal;
          w_next       = w_accept ? ST_READ : ST_IDLE;
        end
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  // Datapath registers; BUSYWAIT freezes everything via the state guards.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_instr <= 32'h0;
      r_cnt   <= 3'd0;
      r_zero  <= 1'b0;
      r_data1 <= 8'h00;
      r_data2 <= 8'h00;
      r_sel   <= 3'd0;
      r_wdata <= 8'h00;
    end else begin
      if (w_accept) r_instr <= INSTR;
      if ((r_state == ST_READ) && !BUSYWAIT) begin
        r_cnt <= c_WAIT_LOAD;
        // j and unknown opcodes leave the ALU inputs untouched
        if (!w_is_jump && !w_illegal) begin
          r_data1 <= w_op1;
          r_data2 <= w_op2;
          r_sel   <= w_select;
        end
      end
      if ((r_state == ST_EXEC) && !BUSYWAIT) begin
        if (r_cnt == 3'd0) begin
          r_wdata <= ALU_RESULT;
          r_zero  <= ALU_ZERO;
        end else begin
          r_cnt <= r_cnt - 3'd1;
        end
      end
    end
  end

  assign READREG1      = r_instr[10:8];
  assign READREG2      = r_instr[2:0];
  assign ALU_DATA1     = r_data1;
  assign ALU_DATA2     = r_data2;
  assign ALU_SELECT    = r_sel;
  assign WRITE_ADDR    = r_instr[18:16];
  assign WRITE_DATA    = r_wdata;
  assign BRANCH_OFFSET = r_instr[23:16];

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Directed self-checking bench for alu_issue_ctrl with a small
//            register file and combinational ALU model around the DUT.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;

  localparam int WAIT = 2;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        INSTR_VALID = 1'b0;
  logic [31:0] INSTR = 32'h0;
  logic        INSTR_READY;
  logic        BUSYWAIT = 1'b0;
  logic [2:0]  READREG1, READREG2;
  logic [7:0]  REGOUT1, REGOUT2;
  logic [7:0]  ALU_DATA1, ALU_DATA2;
  logic [2:0]  ALU_SELECT;
  logic [7:0]  ALU_RESULT;
  logic        ALU_ZERO;
  logic        WRITE_EN;
  logic [2:0]  WRITE_ADDR;
  logic [7:0]  WRITE_DATA;
  logic        BRANCH_TAKEN;
  logic [7:0]  BRANCH_OFFSET;
  logic        ILLEGAL;

  int n_checks = 0;
  int n_err    = 0;
  int n_we     = 0;
  int n_br     = 0;
  int n_ill    = 0;
  int snap_we, snap_br, snap_ill;

  logic [7:0] regs [8];

  always #5 CLK = ~CLK;

  alu_issue_ctrl #(.ALU_WAIT(WAIT)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .INSTR_VALID(INSTR_VALID), .INSTR(INSTR), .INSTR_READY(INSTR_READY),
    .BUSYWAIT(BUSYWAIT),
    .READREG1(READREG1), .READREG2(READREG2),
    .REGOUT1(REGOUT1), .REGOUT2(REGOUT2),
    .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT),
    .ALU_RESULT(ALU_RESULT), .ALU_ZERO(ALU_ZERO),
    .WRITE_EN(WRITE_EN), .WRITE_ADDR(WRITE_ADDR), .WRITE_DATA(WRITE_DATA),
    .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_OFFSET(BRANCH_OFFSET),
    .ILLEGAL(ILLEGAL)
  );

  // Register file and ALU models
  assign REGOUT1 = regs[READREG1];
  assign REGOUT2 = regs[READREG2];

  always_comb begin
    case (ALU_SELECT)
      3'b000:  ALU_RESULT = ALU_DATA2;
      3'b001:  ALU_RESULT = ALU_DATA1 + ALU_DATA2;
      3'b010:  ALU_RESULT = ALU_DATA1 & ALU_DATA2;
      3'b011:  ALU_RESULT = ALU_DATA1 | ALU_DATA2;
      default: ALU_RESULT = 8'h00;
    endcase
  end
  assign ALU_ZERO = (ALU_RESULT == 8'h00);

  // Strobe counters sampled mid-cycle
  always @(negedge CLK) begin
    if (WRITE_EN === 1'b1)     n_we  <= n_we + 1;
    if (BRANCH_TAKEN === 1'b1) n_br  <= n_br + 1;
    if (ILLEGAL === 1'b1)      n_ill <= n_ill + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction for a single accepting edge, then scramble INSTR.
  task automatic accept(input logic [31:0] ins);
    INSTR       = ins;
    INSTR_VALID = 1'b1;
    step(1);
    INSTR_VALID = 1'b0;
    INSTR       = 32'hFFFF_FFFF;
  endtask

  function automatic logic [63:0] all_outs();
    return {16'h0, INSTR_READY, READREG1, READREG2, ALU_DATA1, ALU_DATA2, ALU_SELECT,
            WRITE_EN, WRITE_ADDR, WRITE_DATA, BRANCH_TAKEN, BRANCH_OFFSET, ILLEGAL};
  endfunction

  function automatic logic [63:0] strobes();
    return {61'h0, WRITE_EN, BRANCH_TAKEN, ILLEGAL};
  endfunction

  initial begin
    regs[0] = 8'h00; regs[1] = 8'h05; regs[2] = 8'h07; regs[3] = 8'h80;
    regs[4] = 8'h11; regs[5] = 8'h11; regs[6] = 8'h12; regs[7] = 8'h00;

    // ---- reset state ----
    step(2);
    check("reset_outputs", all_outs(), 64'h0);
    RESET_N = 1'b1;
    #1;
    check("ready_after_reset", 64'(INSTR_READY), 64'h1);
    step(1);

    // ---- loadi r3 <- 0x2A ----
    snap_we = n_we;
    accept(32'h0003_002A);
    step(1);
    check("loadi_data1", 64'(ALU_DATA1), 64'h00);
    check("loadi_data2", 64'(ALU_DATA2), 64'h2A);
    check("loadi_sel", 64'(ALU_SELECT), 64'h0);
    step(WAIT - 1);
    check("loadi_no_early_strobe", strobes(), 64'h0);
    step(1);
    check("loadi_commit_strobes", strobes(), 64'b100);
    check("loadi_waddr", 64'(WRITE_ADDR), 64'h3);
    check("loadi_wdata", 64'(WRITE_DATA), 64'h2A);
    step(1);
    check("loadi_we_drop", 64'(WRITE_EN), 64'h0);
    check("loadi_we_count", 64'(n_we - snap_we), 64'h1);

    // ---- sub r7 <- r1 - r2 = 0x05 - 0x07 ----
    accept(32'h0307_0102);
    step(1);
    check("sub_data1", 64'(ALU_DATA1), 64'h05);
    check("sub_data2", 64'(ALU_DATA2), 64'hF9);
    check("sub_sel", 64'(ALU_SELECT), 64'h1);
    step(WAIT);
    check("sub_we", 64'(WRITE_EN), 64'h1);
    check("sub_waddr", 64'(WRITE_ADDR), 64'h7);
    check("sub_wdata", 64'(WRITE_DATA), 64'hFE);
    step(1);

    // ---- sub with r3 = 0x80: negation wraps to itself ----
    accept(32'h0307_0103);
    step(1);
    check("sub80_data2", 64'(ALU_DATA2), 64'h80);
    step(WAIT);
    check("sub80_wdata", 64'(WRITE_DATA), 64'h85);
    step(1);

    // ---- beq r4 == r5, offset 0xFE: taken ----
    snap_br = n_br;
    accept(32'h07FE_0405);
    step(1);
    check("beq_data2", 64'(ALU_DATA2), 64'hEF);
    step(WAIT);
    check("beq_taken_strobes", strobes(), 64'b010);
    check("beq_offset", 64'(BRANCH_OFFSET), 64'hFE);
    step(1);
    check("beq_taken_drop", 64'(BRANCH_TAKEN), 64'h0);
    check("beq_taken_count", 64'(n_br - snap_br), 64'h1);

    // ---- beq r4 != r6: not taken ----
    accept(32'h07FE_0406);
    step(1 + WAIT);
    check("beq_not_taken_strobes", strobes(), 64'b000);
    step(1);

    // ---- j: branch always, ALU inputs unchanged from previous beq ----
    accept(32'h0605_0000);
    step(1);
    check("j_alu_hold", 64'({ALU_DATA1, ALU_DATA2, ALU_SELECT}), 64'({8'h11, 8'hEE, 3'b001}));
    step(WAIT);
    check("j_strobes", strobes(), 64'b010);
    check("j_offset", 64'(BRANCH_OFFSET), 64'h05);
    step(1);

    // ---- stall in COMMIT: loadi r2 <- 0x55 ----
    snap_we = n_we;
    accept(32'h0002_0055);
    step(1 + WAIT);
    BUSYWAIT = 1'b1;
    #1;
    check("stall_strobe_c0", strobes(), 64'h0);
    check("stall_ready_c0", 64'(INSTR_READY), 64'h0);
    for (int i = 1; i < 4; i++) begin
      step(1);
      check($sformatf("stall_strobe_c%0d", i), strobes(), 64'h0);
      check($sformatf("stall_ready_c%0d", i), 64'(INSTR_READY), 64'h0);
    end
    BUSYWAIT = 1'b0;
    #1;
    check("stall_release_we", 64'(WRITE_EN), 64'h1);
    check("stall_release_wdata", 64'(WRITE_DATA), 64'h55);
    check("stall_release_waddr", 64'(WRITE_ADDR), 64'h2);
    step(1);
    check("stall_we_drop", 64'(WRITE_EN), 64'h0);
    check("stall_we_count", 64'(n_we - snap_we), 64'h1);

    // ---- back-to-back: add r6 <- r1 + r2, then illegal 0x3F ----
    snap_ill = n_ill;
    snap_we  = n_we;
    snap_br  = n_br;
    INSTR       = 32'h0206_0102;
    INSTR_VALID = 1'b1;
    step(1);
    INSTR = 32'h3F00_0000;
    step(1);
    check("b2b_ready_exec", 64'(INSTR_READY), 64'h0);
    check("b2b_add_sel", 64'(ALU_SELECT), 64'h1);
    step(WAIT);
    check("b2b_add_strobes", strobes(), 64'b100);
    check("b2b_add_wdata", 64'(WRITE_DATA), 64'h0C);
    check("b2b_ready_commit", 64'(INSTR_READY), 64'h1);
    step(1);
    INSTR_VALID = 1'b0;
    INSTR       = 32'hFFFF_FFFF;
    check("b2b_after_accept_strobes", strobes(), 64'h0);
    step(1);
    check("ill_alu_hold", 64'({ALU_DATA1, ALU_DATA2, ALU_SELECT}), 64'({8'h05, 8'h07, 3'b001}));
    step(WAIT);
    check("ill_strobes", strobes(), 64'b001);
    step(1);
    check("ill_drop", 64'(ILLEGAL), 64'h0);
    check("ill_count", 64'(n_ill - snap_ill), 64'h1);
    check("b2b_we_count", 64'(n_we - snap_we), 64'h1);
    check("b2b_br_count", 64'(n_br - snap_br), 64'h0);

    // ---- asynchronous reset in the middle of EXEC of an add ----
    snap_we = n_we;
    accept(32'h0206_0102);
    step(1);
    #2;
    RESET_N = 1'b0;
    #1;
    check("midexec_reset_outputs", all_outs(), 64'h0);
    step(1);
    RESET_N = 1'b1;
    #1;
    check("midexec_ready_after", 64'(INSTR_READY), 64'h1);
    step(4);
    check("midexec_no_write", 64'(n_we - snap_we), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Operand and control driver on the issue side of the 8-bit ALU: accepts a 32-bit instruction over a valid/ready handshake and reads the register file.
- Drives the ALU inputs (DATA1, DATA2, SELECT), samples the ALU outputs (RESULT, ZERO) after a programmable settle time, then issues one writeback or branch decision.
- Sits between instruction fetch and the ALU/register file, and stalls on memory BUSYWAIT.

Parameters:
- ALU_WAIT, 1, number of EXEC cycles between driving the ALU inputs and sampling RESULT/ZERO (legal range 1..7; covers the 2-unit add delay at the system clock).

Ports:
- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- INSTR_VALID  in  1  instruction presented
- INSTR  in  32  fields: OP[31:24], RD/OFFSET[23:16], RT[15:8], RS/IMM[7:0]
- INSTR_READY  out  1  block can accept an instruction
- BUSYWAIT  in  1  memory stall; freezes the FSM
- READREG1  out  3  register file read address, = RT[10:8]
- READREG2  out  3  register file read address, = RS[2:0]
- REGOUT1  in  8  register file read data, port 1 (asynchronous read)
- REGOUT2  in  8  register file read data, port 2 (asynchronous read)
- ALU_DATA1  out  8  registered ALU operand 1
- ALU_DATA2  out  8  registered ALU operand 2
- ALU_SELECT  out  3  registered ALU op: 000 fwd, 001 add, 010 and, 011 or
- ALU_RESULT  in  8  ALU result
- ALU_ZERO  in  1  ALU zero flag
- WRITE_EN  out  1  one-cycle register writeback strobe
- WRITE_ADDR  out  3  = RD[18:16]
- WRITE_DATA  out  8  latched ALU_RESULT
- BRANCH_TAKEN  out  1  one-cycle strobe
- BRANCH_OFFSET  out  8  signed word offset, = INSTR[23:16]
- ILLEGAL  out  1  one-cycle strobe for an unknown opcode

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - state = IDLE; all outputs 0.
  - An in-flight instruction is discarded: no WRITE_EN, no BRANCH_TAKEN.
- States: IDLE, READ, EXEC, COMMIT.
- Handshake:
  - INSTR_READY = (state==IDLE || state==COMMIT) && !BUSYWAIT.
  - The instruction is accepted on a rising edge with INSTR_VALID && INSTR_READY; INSTR is latched and the next state is READ.
  - A handshake in COMMIT gives back-to-back issue, one instruction per 2+ALU_WAIT cycles.
- READ:
  - READREG1/READREG2 are driven from the latched instruction.
  - At the end of READ, ALU_DATA1, ALU_DATA2 and ALU_SELECT are registered per the opcode table; the wait counter is loaded with ALU_WAIT-1; next state is EXEC.
- EXEC:
  - Decrement the counter each cycle.
  - When the counter is 0: latch ALU_RESULT into WRITE_DATA, latch ALU_ZERO, go to COMMIT.
- COMMIT (one cycle when BUSYWAIT=0):
  - WRITE_EN=1 for writing ops.
  - BRANCH_TAKEN=1 for j, or for beq with the latched ZERO=1.
  - ILLEGAL=1 for an unknown opcode.
  - Next state: READ if a new handshake occurs this cycle, else IDLE.
- Opcode table (op: DATA1, DATA2, SELECT, effect):
  - 0x00 loadi: 0, IMM, 000, write
  - 0x01 mov: 0, REGOUT2, 000, write
  - 0x02 add: REGOUT1, REGOUT2, 001, write
  - 0x03 sub: REGOUT1, -REGOUT2 (8-bit two's complement, wraps; 0x80 stays 0x80), 001, write
  - 0x04 and: REGOUT1, REGOUT2, 010, write
  - 0x05 or: REGOUT1, REGOUT2, 011, write
  - 0x06 j: ALU inputs unchanged, branch always, no write
  - 0x07 beq: same operands as sub, branch if ZERO, no write
  - other: no ALU change, ILLEGAL only
- Latency:
  - Handshake edge E0; COMMIT occupies the cycle after edge E0+1+ALU_WAIT.
  - With ALU_WAIT=1, WRITE_EN is high in the 3rd cycle after acceptance.
- BUSYWAIT=1 in READ, EXEC or COMMIT:
  - State, counter and all registers hold.
  - In COMMIT, WRITE_EN, BRANCH_TAKEN and ILLEGAL are gated to 0.
  - Exactly one strobe is issued, in the first COMMIT cycle with BUSYWAIT=0.
- Arithmetic is 8-bit modulo; overflow is ignored. ZERO comes from the ALU only, never recomputed locally.
- INSTR changes while no handshake is in progress are ignored.

Decomposition:
- Shared package cpu_defs: opcode constants OP_LOADI..OP_BEQ, ALU select constants SEL_FWD/SEL_ADD/SEL_AND/SEL_OR, state encoding.
- Sub-module alu_instr_decode (combinational). Input: OP. Outputs: select, use_imm, negate_op2, zero_op1, writes, is_jump, is_beq, illegal.

Test Plan:
- Reset sequencing: RESET_N low mid-EXEC of add -> all outputs 0 immediately, no WRITE_EN afterwards; INSTR_READY=1 after release.
- loadi directed check: INSTR=0x00_03_00_2A -> ALU_DATA2=0x2A, SELECT=000; with the ALU model, WRITE_EN pulses once, WRITE_ADDR=3, WRITE_DATA=0x2A, 3 cycles after acceptance.
- sub wrap: sub with r1=0x05, r2=0x07 -> ALU_DATA2=0xF9, WRITE_DATA=0xFE; with r2=0x80 -> ALU_DATA2=0x80.
- beq: r1=r2=0x11, OFFSET=0xFE -> BRANCH_TAKEN=1 for one cycle, BRANCH_OFFSET=0xFE, WRITE_EN=0; with r2=0x12 -> BRANCH_TAKEN=0.
- Stall: BUSYWAIT held high 4 cycles during COMMIT -> no strobe while high; exactly one WRITE_EN on the first low cycle; INSTR_READY=0 throughout the stall.
- Back-to-back and illegal: INSTR_VALID held with add, then opcode 0x3F, ALU_WAIT=2 -> second accepted in the add's COMMIT cycle; the illegal gives ILLEGAL=1 once and no write or branch.
